// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_arb_pkg
//   Shared constants and helpers for the round-robin / fixed-priority
//   N:1 registered mux.
//   MODE_RR    : round-robin arbitration, search starts at the pointer
//   MODE_FIXED : fixed priority, lowest channel index wins
package rr_mux_arb_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  typedef enum logic {
    ARB_ROUND_ROBIN = 1'b0,
    ARB_FIXED_PRIO  = 1'b1
  } arb_mode_e;

  // Index that follows idx in a ring of n channels.
  function automatic int next_index(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// rr_mux_arb_if
//   Handshake bundle between NCH producers, the arbitrating mux, and one
//   shared consumer.
//   in_valid  [NCH]        per-channel request
//   in_data   [NCH*WIDTH]  channel i at bits [i*WIDTH +: WIDTH]
//   in_ready  [NCH]        one-hot or zero grant back to the producers
//   out_valid              output register holds a word
//   out_data  [WIDTH]      registered selected word
//   out_sel   [SELW]       channel that supplied out_data
//   out_ready              consumer accepts the word
//   slave  : the mux itself
//   master : the producers/consumer environment
interface rr_mux_arb_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) ();
  import rr_mux_arb_pkg::*;

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_mux_arb_arbiter.sv
// rr_arbiter
//   Combinational grant over NCH requests plus the round-robin pointer.
//   clk, rst  : clock, synchronous active-high reset
//   req       : request vector
//   advance   : a transfer happens this cycle for the granted channel
//   gnt       : one-hot grant (zero when nothing requests)
//   gnt_idx   : binary index of the granted channel
//   gnt_any   : some channel is granted
//   ptr       : current round-robin start index (always 0 in fixed mode)
module rr_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = 2,
  parameter int MODE = MODE_RR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            advance,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any,
  output logic [SELW-1:0] ptr
);

  logic [SELW-1:0] base;
  logic [SELW:0]   cand;

  // Walk the ring starting at base; the first requesting channel wins.
  // cand is one bit wider so the wrap past NCH-1 can be detected even
  // when NCH is a power of two.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    base    = (MODE == MODE_FIXED) ? '0 : ptr;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, base} + (SELW+1)'(k);
      if (cand >= (SELW+1)'(NCH)) begin
        cand = cand - (SELW+1)'(NCH);
      end
      if (!gnt_any && req[cand[SELW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[SELW-1:0];
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves just past the channel that transferred; it freezes when
  // nothing transfers and never moves in fixed-priority mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == MODE_RR && advance) begin
      ptr <= SELW'(next_index(int'(gnt_idx), NCH));
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb
//   N:1 registered data mux whose select comes from an internal
//   round-robin (MODE=0) or fixed-priority (MODE=1) arbiter.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_mux_arb_if slave modport (in_valid/in_data/in_ready,
//          out_valid/out_data/out_sel/out_ready)
//   One word per cycle; one cycle from input transfer to out_valid.
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = MODE_RR
) (
  input  logic         clk,
  input  logic         rst,
  rr_mux_arb_if.slave  bus
);

  logic             load;
  logic             transfer;
  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_any;
  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] sel_data;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;

  // The output register can take a new word when it is empty or being
  // drained this cycle, which gives full throughput with no bubble.
  // Nothing is granted or transferred while reset is asserted.
  always_comb begin
    load        = !out_valid_q || bus.out_ready;
    transfer    = load && gnt_any && !rst;
    bus.in_ready = (load && !rst) ? gnt : '0;
    sel_data    = bus.in_data[gnt_idx*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.in_valid),
    .advance (transfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any),
    .ptr     (ptr)
  );

  // Output register: capture the granted word on load, empty on load with
  // no request (data/sel keep their last values), hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_sel_q   <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb
//   Drives one round-robin and one fixed-priority instance with the same
//   inputs and checks both against a cycle-level model of the arbitration
//   rules, followed by randomized traffic that obeys the producer rule.
module tb_rr_mux_arb;
  import rr_mux_arb_pkg::*;

  localparam int W    = 8;
  localparam int NCH  = 4;
  localparam int SELW = 2;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  rr_mux_arb_if #(.WIDTH(W), .NCH(NCH), .SELW(SELW)) bus0 ();
  rr_mux_arb_if #(.WIDTH(W), .NCH(NCH), .SELW(SELW)) bus1 ();

  rr_mux_arb #(.WIDTH(W), .NCH(NCH), .SELW(SELW), .MODE(MODE_RR)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  rr_mux_arb #(.WIDTH(W), .NCH(NCH), .SELW(SELW), .MODE(MODE_FIXED)) dut_fx (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state per instance (0 = round-robin, 1 = fixed priority).
  bit         m_known;
  bit         m_valid [2];
  logic [7:0] m_data  [2];
  int         m_sel   [2];
  int         m_ptr   [2];
  logic [NCH-1:0] exp_rdy0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requesting channel when scanning the ring from start; -1 if none.
  function automatic int pick(input logic [NCH-1:0] v, input int start);
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (start + k) % NCH;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: drive on the falling edge, check 1 time unit later,
  // then advance the model to what the next rising edge should produce.
  task automatic applyStimulus(input logic rstv, input logic [NCH-1:0] v,
                               input logic [NCH*W-1:0] d, input logic ordy);
    logic [NCH-1:0] obs_rdy [2];
    logic           obs_vld [2];
    logic [7:0]     obs_dat [2];
    logic [SELW-1:0] obs_sel [2];
    @(negedge clk);
    rst            = rstv;
    bus0.in_valid  = v;
    bus0.in_data   = d;
    bus0.out_ready = ordy;
    bus1.in_valid  = v;
    bus1.in_data   = d;
    bus1.out_ready = ordy;
    #1;
    obs_rdy[0] = bus0.in_ready;  obs_rdy[1] = bus1.in_ready;
    obs_vld[0] = bus0.out_valid; obs_vld[1] = bus1.out_valid;
    obs_dat[0] = bus0.out_data;  obs_dat[1] = bus1.out_data;
    obs_sel[0] = bus0.out_sel;   obs_sel[1] = bus1.out_sel;
    for (int i = 0; i < 2; i++) begin
      bit load;
      int g;
      logic [NCH-1:0] er;
      load = !m_valid[i] || ordy;
      g    = pick(v, (i == 0) ? m_ptr[0] : 0);
      er   = (!rstv && load && g >= 0) ? NCH'(1 << g) : '0;
      if (i == 0) exp_rdy0 = er;
      checkOutput(i == 0 ? "rr_in_ready" : "fx_in_ready", 32'(obs_rdy[i]), 32'(er));
      if (m_known) begin
        checkOutput(i == 0 ? "rr_out_valid" : "fx_out_valid", 32'(obs_vld[i]), 32'(m_valid[i]));
        checkOutput(i == 0 ? "rr_out_data" : "fx_out_data", 32'(obs_dat[i]), 32'(m_data[i]));
        checkOutput(i == 0 ? "rr_out_sel" : "fx_out_sel", 32'(obs_sel[i]), 32'(m_sel[i]));
      end
      if (rstv) begin
        m_valid[i] = 1'b0;
        m_data[i]  = '0;
        m_sel[i]   = 0;
        m_ptr[i]   = 0;
      end else if (load) begin
        if (g >= 0) begin
          m_valid[i] = 1'b1;
          m_data[i]  = d[g*W +: W];
          m_sel[i]   = g;
          if (i == 0) m_ptr[0] = (g + 1) % NCH;
        end else begin
          m_valid[i] = 1'b0;
        end
      end
    end
    if (rstv) m_known = 1'b1;
  endtask

  localparam logic [NCH*W-1:0] DATA_SEQ = {8'h33, 8'h22, 8'h11, 8'h00};

  initial begin
    int exp_seq [6];
    logic [NCH-1:0] cur_v;
    logic [NCH*W-1:0] cur_d;
    vectors     = 0;
    miscompares = 0;
    m_known     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_data[i] = 0; m_sel[i] = 0; m_ptr[i] = 0;
    end
    rst = 1'b1;
    bus0.in_valid = '0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = '0; bus1.in_data = '0; bus1.out_ready = 1'b0;

    // 1: reset then a single request from channel 2
    applyStimulus(1, 4'b0000, '0, 1);
    applyStimulus(1, 4'b0000, '0, 1);
    applyStimulus(0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1);
    checkOutput("t1_in_ready", 32'(bus0.in_ready), 32'h4);
    applyStimulus(0, 4'b0000, '0, 1);
    checkOutput("t1_out_valid", 32'(bus0.out_valid), 32'h1);
    checkOutput("t1_out_data", 32'(bus0.out_data), 32'hA5);
    checkOutput("t1_out_sel", 32'(bus0.out_sel), 32'h2);

    // 2: all channels requesting, round-robin rotates 0,1,2,3,0,1
    exp_seq = '{0, 1, 2, 3, 0, 1};
    applyStimulus(1, 4'b0000, '0, 1);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 4'b1111, DATA_SEQ, 1);
      if (k > 0) begin
        checkOutput("t2_rr_sel", 32'(bus0.out_sel), 32'(exp_seq[k-1]));
        checkOutput("t2_rr_valid", 32'(bus0.out_valid), 32'h1);
      end
    end

    // 3: fixed priority with channels 1 and 3 requesting
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 4'b1010, DATA_SEQ, 1);
      checkOutput("t3_fx_rdy3", 32'(bus1.in_ready[3]), 32'h0);
      if (k > 0) checkOutput("t3_fx_sel", 32'(bus1.out_sel), 32'h1);
    end

    // 4: backpressure for 5 cycles, then release
    applyStimulus(0, 4'b1111, DATA_SEQ, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 4'b1111, DATA_SEQ, 0);
      checkOutput("t4_in_ready", 32'(bus0.in_ready), 32'h0);
    end
    applyStimulus(0, 4'b1111, DATA_SEQ, 1);
    applyStimulus(0, 4'b0000, '0, 1);

    // 5: grant channel 3, go idle, then 0 and 3 request together
    applyStimulus(1, 4'b0000, '0, 1);
    applyStimulus(0, 4'b1000, DATA_SEQ, 1);
    applyStimulus(0, 4'b0000, '0, 1);
    applyStimulus(0, 4'b0000, '0, 1);
    checkOutput("t5_idle_valid", 32'(bus0.out_valid), 32'h0);
    applyStimulus(0, 4'b1001, DATA_SEQ, 1);
    checkOutput("t5_wrap_rdy", 32'(bus0.in_ready), 32'h1);

    // 6: reset while a word is held and channel 2 is pending
    applyStimulus(0, 4'b0100, DATA_SEQ, 0);
    applyStimulus(0, 4'b0101, DATA_SEQ, 0);
    applyStimulus(1, 4'b1111, DATA_SEQ, 0);
    checkOutput("t6_rst_rdy", 32'(bus0.in_ready), 32'h0);
    applyStimulus(0, 4'b1111, DATA_SEQ, 1);
    checkOutput("t6_post_valid", 32'(bus0.out_valid), 32'h0);
    checkOutput("t6_post_rdy", 32'(bus0.in_ready), 32'h1);

    // Random traffic: producers hold until granted, occasionally withdraw.
    cur_v = '0;
    cur_d = '0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!cur_v[c] || exp_rdy0[c] || $urandom_range(0, 9) == 0) begin
          cur_v[c]         = 1'($urandom_range(0, 1));
          cur_d[c*W +: W]  = 8'($urandom);
        end
      end
      applyStimulus(($urandom_range(0, 49) == 0), cur_v, cur_d,
                    ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
